// File: rtl/uart_alu_ctrl_if.sv
// rtl/uart_alu_ctrl_if.sv - receive/transmit byte streams between UART core and command sequencer
interface uart_alu_ctrl_if;
   logic [7:0] rx_tdata;
   logic       rx_tvalid;
   logic       rx_tready;
   logic [7:0] tx_tdata;
   logic       tx_tvalid;
   logic       tx_tready;

   modport master (
      output rx_tdata, rx_tvalid, tx_tready,
      input  rx_tready, tx_tdata, tx_tvalid
   );
   modport slave (
      input  rx_tdata, rx_tvalid, tx_tready,
      output rx_tready, tx_tdata, tx_tvalid
   );
endinterface

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - UART command sequencer: echo, 32-bit add and prescale configuration
// UART_ALU_RESP_HDR_EN prefixes each response with {opcode, 0x00, RLEN lo, RLEN hi}.
module uart_alu_ctrl #(
   parameter logic [15:0] PRESCALE_RST = 16'd13,
   parameter logic [15:0] MAX_LEN      = 16'd1024
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_alu_ctrl_if.slave s,
   input  logic           rx_frame_error_i,
   output logic [15:0]    prescale_o,
   output logic           busy_o,
   output logic           err_o
);
   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hA5;
   localparam logic [7:0] OP_CFG  = 8'hC0;
`ifdef UART_ALU_RESP_HDR_EN
   localparam logic [2:0] ADD_LAST = 3'd7;
`else
   localparam logic [2:0] ADD_LAST = 3'd3;
`endif

   typedef enum logic [3:0] {
      S_OP, S_RSVD, S_LEN_LO, S_LEN_HI, S_ECHO,
      S_ADD_RX, S_ADD_TX, S_CFG_RX, S_DRAIN, S_HDR_TX
   } state_t;

   state_t      state_q, state_d, hdr_next_q, hdr_next_d;
   logic [7:0]  opc_q, opc_d, len_lo_q, len_lo_d, tx_tdata_q, tx_tdata_d;
   logic [15:0] cnt_q, cnt_d, prescale_q, prescale_d;
   logic [31:0] op_q, op_d, acc_q, acc_d;
   logic [55:0] resp_q, resp_d;
   logic [2:0]  resp_left_q, resp_left_d;
   logic [1:0]  bidx_q, bidx_d;
   logic        tx_tvalid_q, tx_tvalid_d, rx_tready_q, rx_tready_d;
   logic        busy_q, busy_d, err_q, err_d;

   logic        rx_fire, tx_fire, start_en, opc_ok;
   logic [2:0]  start_last;
   logic [63:0] start_vec;
   logic [15:0] len_w, cfg_w;
   logic [31:0] op_w, sum_w;

   function automatic logic [63:0] add_resp(input logic [31:0] sum);
`ifdef UART_ALU_RESP_HDR_EN
      return {sum, 16'd8, 8'h00, OP_ADD};
`else
      return {32'd0, sum};
`endif
   endfunction

   assign rx_fire = s.rx_tvalid && rx_tready_q;
   assign tx_fire = tx_tvalid_q && s.tx_tready;
   assign len_w   = {s.rx_tdata, len_lo_q};
   assign cfg_w   = {s.rx_tdata, op_q[7:0]};
   assign op_w    = op_q | ({24'd0, s.rx_tdata} << {bidx_q, 3'b000});
   assign sum_w   = acc_q + op_w;
   assign opc_ok  = (opc_q == OP_ECHO) || (opc_q == OP_ADD) || (opc_q == OP_CFG);

   always_comb begin
      state_d     = state_q;
      hdr_next_d  = hdr_next_q;
      opc_d       = opc_q;
      len_lo_d    = len_lo_q;
      tx_tdata_d  = tx_tdata_q;
      tx_tvalid_d = tx_tvalid_q && !tx_fire;
      cnt_d       = cnt_q;
      prescale_d  = prescale_q;
      op_d        = op_q;
      acc_d       = acc_q;
      resp_d      = resp_q;
      resp_left_d = resp_left_q;
      bidx_d      = bidx_q;
      err_d       = err_q;
      start_en    = 1'b0;
      start_vec   = 64'd0;
      start_last  = 3'd0;

      case (state_q)
         S_OP:     if (rx_fire) begin opc_d = s.rx_tdata; state_d = S_RSVD; end
         S_RSVD:   if (rx_fire) state_d = S_LEN_LO;
         S_LEN_LO: if (rx_fire) begin len_lo_d = s.rx_tdata; state_d = S_LEN_HI; end
         S_LEN_HI: if (rx_fire) begin
            cnt_d   = len_w - 16'd4;
            state_d = S_OP;
            if (len_w < 16'd4 || len_w > MAX_LEN || !opc_ok) begin
               err_d   = 1'b1;
               cnt_d   = (len_w > 16'd4) ? len_w - 16'd4 : 16'd0;
               state_d = (len_w > 16'd4) ? S_DRAIN : S_OP;
            end else if (len_w == 16'd4) begin
               if (opc_q == OP_ADD) begin
                  start_en   = 1'b1;
                  start_vec  = add_resp(32'd0);
                  start_last = ADD_LAST;
                  state_d    = S_ADD_TX;
               end
            end else if (opc_q == OP_ECHO) begin
`ifdef UART_ALU_RESP_HDR_EN
               start_en   = 1'b1;
               start_vec  = {32'd0, len_w, 8'h00, OP_ECHO};
               start_last = 3'd3;
               hdr_next_d = S_ECHO;
               state_d    = S_HDR_TX;
`else
               state_d = S_ECHO;
`endif
            end else if (opc_q == OP_ADD) begin
               state_d = S_ADD_RX;
            end else if (len_w == 16'd6) begin
               state_d = S_CFG_RX;
            end else begin
               err_d   = 1'b1;
               state_d = S_DRAIN;
            end
         end
         // The tx output register doubles as the one-byte echo holding register.
         S_ECHO: begin
            if (rx_fire) begin
               tx_tvalid_d = 1'b1;
               tx_tdata_d  = s.rx_tdata;
               cnt_d       = cnt_q - 16'd1;
            end else if (tx_fire && cnt_q == 16'd0) begin
               err_d   = 1'b0;
               state_d = S_OP;
            end
         end
         S_ADD_RX: if (rx_fire) begin
            cnt_d = cnt_q - 16'd1;
            if (bidx_q == 2'd3 || cnt_q == 16'd1) begin
               acc_d  = sum_w;
               op_d   = 32'd0;
               bidx_d = 2'd0;
            end else begin
               op_d   = op_w;
               bidx_d = bidx_q + 2'd1;
            end
            if (cnt_q == 16'd1) begin
               start_en   = 1'b1;
               start_vec  = add_resp(sum_w);
               start_last = ADD_LAST;
               state_d    = S_ADD_TX;
            end
         end
         S_ADD_TX, S_HDR_TX: if (tx_fire) begin
            if (resp_left_q != 3'd0) begin
               tx_tvalid_d = 1'b1;
               tx_tdata_d  = resp_q[7:0];
               resp_d      = resp_q >> 8;
               resp_left_d = resp_left_q - 3'd1;
            end else begin
               acc_d   = 32'd0;
               state_d = (state_q == S_HDR_TX) ? hdr_next_q : S_OP;
            end
         end
         S_CFG_RX: if (rx_fire) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd2) begin
               op_d = {24'd0, s.rx_tdata};
            end else begin
               op_d    = 32'd0;
               state_d = S_OP;
               if (cfg_w == 16'd0) begin
                  err_d = 1'b1;
               end else begin
                  prescale_d = cfg_w;
`ifdef UART_ALU_RESP_HDR_EN
                  start_en   = 1'b1;
                  start_vec  = {32'd0, 16'd4, 8'h00, OP_CFG};
                  start_last = 3'd3;
                  hdr_next_d = S_OP;
                  state_d    = S_HDR_TX;
`endif
               end
            end
         end
         S_DRAIN: if (rx_fire) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = S_OP;
         end
         default: state_d = S_OP;
      endcase

      if (start_en) begin
         tx_tvalid_d = 1'b1;
         tx_tdata_d  = start_vec[7:0];
         resp_d      = start_vec[63:8];
         resp_left_d = start_last;
      end

      if (rx_frame_error_i) begin
         state_d     = S_OP;
         err_d       = 1'b1;
         cnt_d       = 16'd0;
         op_d        = 32'd0;
         acc_d       = 32'd0;
         bidx_d      = 2'd0;
         resp_d      = 56'd0;
         resp_left_d = 3'd0;
         tx_tvalid_d = 1'b0;
         tx_tdata_d  = 8'd0;
      end

      case (state_d)
         S_OP, S_RSVD, S_LEN_LO, S_LEN_HI, S_ADD_RX, S_CFG_RX, S_DRAIN: rx_tready_d = 1'b1;
         S_ECHO:  rx_tready_d = !tx_tvalid_d;
         default: rx_tready_d = 1'b0;
      endcase
      busy_d = (state_d != S_OP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_OP;
         hdr_next_q  <= S_OP;
         opc_q       <= 8'd0;
         len_lo_q    <= 8'd0;
         tx_tdata_q  <= 8'd0;
         tx_tvalid_q <= 1'b0;
         rx_tready_q <= 1'b0;
         cnt_q       <= 16'd0;
         prescale_q  <= PRESCALE_RST;
         op_q        <= 32'd0;
         acc_q       <= 32'd0;
         resp_q      <= 56'd0;
         resp_left_q <= 3'd0;
         bidx_q      <= 2'd0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_next_q  <= hdr_next_d;
         opc_q       <= opc_d;
         len_lo_q    <= len_lo_d;
         tx_tdata_q  <= tx_tdata_d;
         tx_tvalid_q <= tx_tvalid_d;
         rx_tready_q <= rx_tready_d;
         cnt_q       <= cnt_d;
         prescale_q  <= prescale_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         resp_q      <= resp_d;
         resp_left_q <= resp_left_d;
         bidx_q      <= bidx_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign s.rx_tready = rx_tready_q;
   assign s.tx_tdata  = tx_tdata_q;
   assign s.tx_tvalid = tx_tvalid_q;
   assign prescale_o  = prescale_q;
   assign busy_o      = busy_q;
   assign err_o       = err_q;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - self-checking bench for uart_alu_ctrl against a packet-level model
module tb_uart_alu_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_frame_error_i = 1'b0;
   logic [15:0] prescale_o;
   logic        busy_o;
   logic        err_o;

   uart_alu_ctrl_if bus();

   uart_alu_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s                (bus.slave),
      .rx_frame_error_i (rx_frame_error_i),
      .prescale_o       (prescale_o),
      .busy_o           (busy_o),
      .err_o            (err_o)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          rdy_mode = 2;
   logic [7:0]  got[$];
   logic [7:0]  p[$];
   logic [7:0]  exp_q[$];
   logic [15:0] m_prescale = 16'd13;
   logic        m_err = 1'b0;

   always @(negedge clk)
      if (rst_n && bus.tx_tvalid && bus.tx_tready) got.push_back(bus.tx_tdata);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       bus.tx_tready = 1'b0;
         1:       bus.tx_tready = ($urandom_range(0, 3) != 0);
         default: bus.tx_tready = 1'b1;
      endcase
   endtask

   task automatic send_byte(input logic [7:0] b);
      int   n;
      logic acc;
      n = 0;
      bus.rx_tvalid = 1'b1;
      bus.rx_tdata  = b;
      do begin
         acc = bus.rx_tready;
         tick();
         n++;
      end while (!acc && n < 500);
      bus.rx_tvalid = 1'b0;
      if (!acc) chk("rx_accept_timeout", {31'd0, acc}, 32'd1);
   endtask

   task automatic push_hdr(inout logic [7:0] r[$], input logic [7:0] opc, input logic [15:0] rlen);
`ifdef UART_ALU_RESP_HDR_EN
      r.push_back(opc);
      r.push_back(8'h00);
      r.push_back(rlen[7:0]);
      r.push_back(rlen[15:8]);
`endif
   endtask

   // Packet-level reference: whole packet in, expected response bytes and flag updates out.
   task automatic model(input logic [7:0] pk[$], output logic [7:0] r[$]);
      int          len;
      logic [31:0] sum;
      logic [15:0] v;
      r = {};
      len = int'({pk[3], pk[2]});
      if (len < 4 || len > 1024 || !(pk[0] inside {8'hEC, 8'hA5, 8'hC0})) begin
         m_err = 1'b1;
         return;
      end
      if (pk[0] == 8'hEC) begin
         if (len > 4) begin
            push_hdr(r, 8'hEC, 16'(len));
            for (int i = 4; i < len; i++) r.push_back(pk[i]);
            m_err = 1'b0;
         end
      end else if (pk[0] == 8'hA5) begin
         sum = 32'd0;
         for (int i = 4; i < len; i++) sum = sum + (32'(pk[i]) << (8 * ((i - 4) % 4)));
         push_hdr(r, 8'hA5, 16'd8);
         for (int k = 0; k < 4; k++) r.push_back(sum[8*k +: 8]);
      end else if (len != 4) begin
         if (len != 6) begin
            m_err = 1'b1;
         end else begin
            v = {pk[5], pk[4]};
            if (v == 16'd0) m_err = 1'b1;
            else begin
               m_prescale = v;
               push_hdr(r, 8'hC0, 16'd4);
            end
         end
      end
   endtask

   task automatic finish_pkt(input string tag, input logic [7:0] e[$]);
      int n;
      n = 0;
      while ((got.size() < e.size() || busy_o) && n < 2000) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, {31'd0, n < 2000}, 32'd1);
      repeat (4) tick();
      chk({tag, "_count"}, got.size(), e.size());
      for (int i = 0; i < e.size() && i < got.size(); i++) chk({tag, "_byte"}, {24'd0, got[i]}, {24'd0, e[i]});
      chk({tag, "_err"}, {31'd0, err_o}, {31'd0, m_err});
      chk({tag, "_prescale"}, {16'd0, prescale_o}, {16'd0, m_prescale});
      chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
   endtask

   task automatic run_pkt(input string tag, input logic [7:0] pk[$]);
      logic [7:0] e[$];
      model(pk, e);
      got.delete();
      foreach (pk[i]) send_byte(pk[i]);
      finish_pkt(tag, e);
   endtask

   initial begin
      int hi;
      int kind;
      int len;
      logic [7:0] opc;

      bus.rx_tvalid = 1'b0;
      bus.rx_tdata  = 8'd0;
      bus.tx_tready = 1'b1;
      repeat (3) tick();
      chk("rst_prescale", {16'd0, prescale_o}, 32'd13);
      chk("rst_tx_tvalid", {31'd0, bus.tx_tvalid}, 32'd0);
      chk("rst_tx_tdata", {24'd0, bus.tx_tdata}, 32'd0);
      chk("rst_rx_tready", {31'd0, bus.rx_tready}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      rst_n = 1'b1;
      tick();
      rdy_mode = 1;

      p = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
      run_pkt("echo3", p);
      p = '{8'hA5, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};
      run_pkt("add_wrap", p);
      p = '{8'hA5, 8'h00, 8'h06, 8'h00, 8'h34, 8'h12};
      run_pkt("add_partial", p);
      p = '{8'hC0, 8'h00, 8'h06, 8'h00, 8'h68, 8'h00};
      run_pkt("cfg_68", p);
      chk("cfg_68_const", {16'd0, prescale_o}, 32'h68);
      p = '{8'hC0, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00};
      run_pkt("cfg_zero", p);
      chk("cfg_zero_const", {16'd0, prescale_o}, 32'h68);
      chk("cfg_zero_err", {31'd0, err_o}, 32'd1);
      p = '{8'h77, 8'h00, 8'h06, 8'h00, 8'h12, 8'h34};
      run_pkt("bad_opc", p);
      p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'hAA};
      run_pkt("echo_clr", p);
      chk("echo_clr_err", {31'd0, err_o}, 32'd0);
      p = '{8'hA5, 8'h00, 8'h04, 8'h00};
      run_pkt("add_empty", p);
      p = '{8'hEC, 8'h00, 8'h02, 8'h00};
      run_pkt("len_short", p);
`ifdef UART_ALU_RESP_HDR_EN
      p = '{8'hA5, 8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      run_pkt("hdr_add", p);
`else
      rdy_mode = 0;
      bus.tx_tready = 1'b0;
      got.delete();
      p = '{8'hEC, 8'h00, 8'h0C, 8'h00};
      for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
      model(p, exp_q);
      for (int i = 0; i < 4; i++) send_byte(p[i]);
      chk("lat_not_early", {31'd0, bus.tx_tvalid}, 32'd0);
      send_byte(p[4]);
      chk("lat_valid", {31'd0, bus.tx_tvalid}, 32'd1);
      chk("lat_data", {24'd0, bus.tx_tdata}, {24'd0, p[4]});
      bus.rx_tvalid = 1'b1;
      bus.rx_tdata  = p[5];
      hi = 0;
      repeat (50) begin
         if (bus.rx_tready) hi++;
         tick();
      end
      bus.rx_tvalid = 1'b0;
      chk("bp_rx_tready_low", hi, 0);
      chk("bp_hold_data", {24'd0, bus.tx_tdata}, {24'd0, p[4]});
      chk("bp_no_tx", got.size(), 0);
      rdy_mode = 1;
      for (int i = 5; i < 12; i++) send_byte(p[i]);
      finish_pkt("bp_echo", exp_q);
`endif

      p = '{8'hA5, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02};
      got.delete();
      foreach (p[i]) send_byte(p[i]);
      rx_frame_error_i = 1'b1;
      tick();
      rx_frame_error_i = 1'b0;
      m_err = 1'b1;
      chk("fe_err", {31'd0, err_o}, 32'd1);
      chk("fe_busy", {31'd0, busy_o}, 32'd0);
      chk("fe_tx_tvalid", {31'd0, bus.tx_tvalid}, 32'd0);
      p = '{8'hA5, 8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      run_pkt("fe_after_add", p);

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 9);
         opc  = (kind < 3) ? 8'hEC : (kind < 6) ? 8'hA5 : (kind < 8) ? 8'hC0 : 8'($urandom);
         len  = $urandom_range(4, 20);
         if (opc == 8'hC0 && $urandom_range(0, 3) != 0) len = 6;
         if ($urandom_range(0, 15) == 0) len = $urandom_range(0, 3);
         p = {};
         p.push_back(opc);
         p.push_back(8'($urandom));
         p.push_back(8'(len));
         p.push_back(8'(len >> 8));
         for (int i = 4; i < len; i++)
            p.push_back(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
         run_pkt("rand", p);
      end

      p = '{8'hA5, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02};
      foreach (p[i]) send_byte(p[i]);
      rst_n = 1'b0;
      #1;
      m_err = 1'b0;
      m_prescale = 16'd13;
      chk("mid_rst_prescale", {16'd0, prescale_o}, 32'd13);
      chk("mid_rst_err", {31'd0, err_o}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("mid_rst_tx_tvalid", {31'd0, bus.tx_tvalid}, 32'd0);
      chk("mid_rst_rx_tready", {31'd0, bus.rx_tready}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      p = '{8'hA5, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      run_pkt("after_rst", p);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
